// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Operand-fetch / issue / writeback stage wrapped around an
//               external combinational ALU. It holds a small register file and
//               accepts one command at a time over valid/ready. The two source
//               registers are latched and driven to the ALU for one cycle. The
//               ALU result, carry and zero are captured, the result is written
//               back to the destination register, and the captured values are
//               returned on a response handshake.
//
// Parameters  : WIDTH  data / ALU bus width
//               NREGS  register file depth
//               AW     register address width (2**AW == NREGS)
//
// Ports       : clk, rst_n                   clock, async active-low reset
//               cmd_valid/ready/mode/ra/rb/rd/cin   command channel
//               ld_valid/addr/data           external register load strobe
//               rsp_valid/ready/data/carry/zero     response channel
//               alu_a/b/mode/carry_in/enable_n      ALU drive
//               alu_out/carry_out/zero       ALU results
//
// Config      : ALU_CARRY_CHAIN_EN defined   -> alu_carry_in is the carry_out
//               of the previous operation (cmd_cin is ignored)
//               ALU_CARRY_CHAIN_EN undefined -> alu_carry_in is cmd_cin
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [AW-1:0]    cmd_rd,
    input  logic             cmd_cin,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_mode,
    output logic             alu_carry_in,
    output logic             alu_enable_n,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  opa_q, opb_q;
    logic [2:0]        mode_q;
    logic [AW-1:0]     rd_q;
    logic              cin_q;
    logic [WIDTH-1:0]  res_q;
    logic              res_carry_q;
    logic              res_zero_q;
    logic              carry_flag_q;

    logic              accept;
    logic              cin_sel;

    assign accept = (state_q == S_IDLE) && cmd_valid;

`ifdef ALU_CARRY_CHAIN_EN
    // Chain mode: the carry of the previous operation feeds the next one.
    assign cin_sel = carry_flag_q;
    logic unused_cmd_cin;
    assign unused_cmd_cin = cmd_cin;
`else
    // The carry flag is still tracked so that it reflects the last operation,
    // but it never feeds the ALU in this build.
    assign cin_sel = cmd_cin;
    logic unused_carry_flag;
    assign unused_carry_flag = carry_flag_q;
`endif

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, result capture and carry tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q        <= '0;
            opb_q        <= '0;
            mode_q       <= '0;
            rd_q         <= '0;
            cin_q        <= 1'b0;
            res_q        <= '0;
            res_carry_q  <= 1'b0;
            res_zero_q   <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            if (accept) begin
                // Register reads see the contents before this edge, so a load
                // landing on the same edge is not forwarded.
                opa_q  <= regs_q[cmd_ra];
                opb_q  <= regs_q[cmd_rb];
                mode_q <= cmd_mode;
                rd_q   <= cmd_rd;
                cin_q  <= cin_sel;
            end
            if (state_q == S_EXEC) begin
                res_q        <= alu_out;
                res_carry_q  <= alu_carry_out;
                res_zero_q   <= alu_zero;
                carry_flag_q <= alu_carry_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file: external loads in any state; the ALU writeback is
    // assigned last so it wins over a load to the same register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (ld_valid) begin
                regs_q[ld_addr] <= ld_data;
            end
            if (state_q == S_EXEC) begin
                regs_q[rd_q] <= alu_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the ALU is driven only from the latched operands, so the
    // operand ports hold their last values outside EXEC.
    // ------------------------------------------------------------------
    assign cmd_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_data     = res_q;
    assign rsp_carry    = res_carry_q;
    assign rsp_zero     = res_zero_q;
    assign alu_a        = opa_q;
    assign alu_b        = opb_q;
    assign alu_mode     = mode_q;
    assign alu_carry_in = cin_q;
    assign alu_enable_n = (state_q != S_EXEC);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Scoreboard bench for alu_issue_ctrl. Includes a behavioural
//               ALU (mode 0 AND, 1 OR, 2 XOR, 3 shift-left-with-carry,
//               4 shift-right-with-carry, 5 NOT, 6 SUB, 7 ADD) and a reference
//               model of the register file and carry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    localparam int WIDTH = 32;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_cin;
    logic [2:0]       cmd_mode;
    logic [AW-1:0]    cmd_ra, cmd_rb, cmd_rd;
    logic             ld_valid;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             rsp_valid, rsp_ready, rsp_carry, rsp_zero;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [2:0]       alu_mode;
    logic             alu_carry_in, alu_enable_n, alu_carry_out, alu_zero;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_cin(cmd_cin),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_carry_in(alu_carry_in), .alu_enable_n(alu_enable_n),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero)
    );

    // Behavioural ALU: returns {carry, zero, result}
    function automatic logic [WIDTH+1:0] alu_ref(input logic [2:0] m, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, input logic ci);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] o;
        logic             co;
        s  = '0;
        o  = '0;
        co = 1'b0;
        case (m)
            3'd0: o = a & b;
            3'd1: o = a | b;
            3'd2: o = a ^ b;
            3'd3: begin o = {a[WIDTH-2:0], ci}; co = a[WIDTH-1]; end
            3'd4: begin o = {ci, a[WIDTH-1:1]}; co = a[0]; end
            3'd5: o = ~a;
            3'd6: begin s = {1'b0, a} - {1'b0, b}; o = s[WIDTH-1:0]; co = s[WIDTH]; end
            default: begin
                s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
                o = s[WIDTH-1:0];
                co = s[WIDTH];
            end
        endcase
        return {co, (o == '0), o};
    endfunction

    assign {alu_carry_out, alu_zero, alu_out} = alu_ref(alu_mode, alu_a, alu_b, alu_carry_in);

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       mode;
        logic             cin;
    } op_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             zero;
        int               cyc;
    } rsp_t;

    op_t  op_q[$];
    rsp_t rsp_q[$];

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] m_regs [NREGS];
    logic             m_carry = 1'b0;
    bit               busy = 0;      // a command is outstanding
    int               age  = 0;      // edges since the accept edge
    logic [AW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_val;
    logic             wb_cout;

    bit ld_rand  = 0;
    bit ld_force = 0;
    bit rr_rand  = 0;
    int hold_cnt = 0;
    bit seen     = 0;
    logic [WIDTH-1:0] last_data;
    logic             last_carry, last_zero;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected condition (t=%0t)", name, $time);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'(1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic tick();
        logic [WIDTH+1:0] res;
        bit   acc, wb_edge;
        op_t  o;
        rsp_t r;
        if (ld_rand && !ld_force) begin
            ld_valid = ($urandom_range(0, 3) == 0);
            ld_addr  = AW'($urandom_range(0, NREGS - 1));
            ld_data  = rand_word();
        end
        if (busy && age >= 1 && hold_cnt > 0) begin
            rsp_ready = 1'b0;
            hold_cnt--;
        end else if (rr_rand) begin
            rsp_ready = ($urandom_range(0, 1) == 1);
        end else begin
            rsp_ready = 1'b1;
        end
        #1;
        chk("cmd_ready", cmd_ready, !busy);
        acc = cmd_valid && !busy;
        o = '0;
        r = '0;
        if (acc) begin
            o.a    = m_regs[cmd_ra];
            o.b    = m_regs[cmd_rb];
            o.mode = cmd_mode;
`ifdef ALU_CARRY_CHAIN_EN
            o.cin  = m_carry;
`else
            o.cin  = cmd_cin;
`endif
            res     = alu_ref(o.mode, o.a, o.b, o.cin);
            r.data  = res[WIDTH-1:0];
            r.zero  = res[WIDTH];
            r.carry = res[WIDTH+1];
            // Response is visible in the second cycle after the accept cycle.
            r.cyc   = cyc + 2;
        end
        @(posedge clk);
        wb_edge = busy && (age == 0);
        if (busy) begin
            if (age >= 1 && rsp_ready) busy = 0;
            age++;
        end
        if (ld_valid) m_regs[ld_addr] = ld_data;
        if (wb_edge) begin
            m_regs[wb_rd] = wb_val;   // writeback beats a same-edge load
            m_carry       = wb_cout;
        end
        if (acc) begin
            busy    = 1;
            age     = 0;
            wb_rd   = cmd_rd;
            wb_val  = r.data;
            wb_cout = r.carry;
            op_q.push_back(o);
            rsp_q.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            if (ld_rand) begin
                // Junk on the command port while busy must be ignored.
                cmd_valid = ($urandom_range(0, 1) == 1);
                cmd_mode  = 3'($urandom);
                cmd_ra    = AW'($urandom);
                cmd_rb    = AW'($urandom);
                cmd_rd    = AW'($urandom);
                cmd_cin   = 1'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            n++;
        end
        if (busy) begin
            fail_msg("wait_idle_timeout");
            busy = 0;
        end
    endtask

    task automatic do_ld(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        ld_force = 1;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
        ld_force = 0;
    endtask

    task automatic do_op(input logic [2:0] m, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [AW-1:0] rd, input logic ci, input bit ldwb,
                         input logic [WIDTH-1:0] ldd);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_cin   = ci;
        tick();
        cmd_valid = ld_rand ? 1'($urandom) : 1'b0;
        cmd_mode  = 3'($urandom);
        cmd_ra    = AW'($urandom);
        cmd_rb    = AW'($urandom);
        cmd_cin   = 1'($urandom);
        if (ldwb) begin
            ld_force = 1;
            ld_valid = 1'b1;
            ld_addr  = rd;
            ld_data  = ldd;
        end
        tick();
        ld_force  = 0;
        ld_valid  = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_carry   = 1'b0;
        busy      = 0;
        age       = 0;
        seen      = 0;
        last_data = 32'hDEAD_BEEF;
        op_q.delete();
        rsp_q.delete();
    endtask

    task automatic reset_checks(input string tag);
        #1;
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_alu_enable_n"}, alu_enable_n, 1'b1);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_alu_a"}, alu_a, '0);
        chk({tag, "_alu_b"}, alu_b, '0);
        chk({tag, "_alu_mode"}, alu_mode, '0);
        chk({tag, "_alu_cin"}, alu_carry_in, 1'b0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: checks ALU drive and responses against the queues
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (!alu_enable_n) begin
                    if (op_q.size() == 0) begin
                        fail_msg("alu_enable_unexpected");
                    end else begin
                        chk("alu_a", alu_a, op_q[0].a);
                        chk("alu_b", alu_b, op_q[0].b);
                        chk("alu_mode", alu_mode, op_q[0].mode);
                        chk("alu_carry_in", alu_carry_in, op_q[0].cin);
                        void'(op_q.pop_front());
                    end
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        fail_msg("rsp_valid_unexpected");
                    end else begin
                        if (!seen) begin
                            chk("rsp_latency", cyc, rsp_q[0].cyc);
                            seen = 1;
                        end
                        chk("rsp_data", rsp_data, rsp_q[0].data);
                        chk("rsp_carry", rsp_carry, rsp_q[0].carry);
                        chk("rsp_zero", rsp_zero, rsp_q[0].zero);
                        if (rsp_ready) begin
                            last_data  = rsp_data;
                            last_carry = rsp_carry;
                            last_zero  = rsp_zero;
                            void'(rsp_q.pop_front());
                            seen = 0;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rd    = '0;
        cmd_cin   = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        rsp_ready = 1'b1;
        model_reset();
        reset_checks("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry out and zero result
        do_ld(3'd1, 32'hFFFF_FFFF);
        do_ld(3'd2, 32'h0000_0001);
        do_op(3'd7, 3'd1, 3'd2, 3'd3, 1'b0, 0, '0);
        wait_idle();
        chk("t1_data", last_data, 32'h0);
        chk("t1_carry", last_carry, 1'b1);
        chk("t1_zero", last_zero, 1'b1);

        // XOR with a stalled consumer
        hold_cnt = 3;
        do_op(3'd2, 3'd1, 3'd1, 3'd6, 1'b0, 0, '0);
        wait_idle();
        chk("t2_data", last_data, 32'h0);
        chk("t2_hold_used", hold_cnt, 0);

        // Shift-left-with-carry after a carry-producing ADD
        do_op(3'd7, 3'd1, 3'd2, 3'd3, 1'b0, 0, '0);
        do_op(3'd3, 3'd2, 3'd2, 3'd7, 1'b0, 0, '0);
        wait_idle();
`ifdef ALU_CARRY_CHAIN_EN
        chk("t3_data", last_data, 32'h3);
`else
        chk("t3_data", last_data, 32'h2);
`endif
        chk("t3_carry", last_carry, 1'b0);

        // Load colliding with writeback to the same register
        do_ld(3'd4, 32'h1234_5678);
        do_ld(3'd5, 32'h0);
        do_op(3'd1, 3'd4, 3'd5, 3'd3, 1'b0, 1, 32'hA5A5_A5A5);
        do_op(3'd1, 3'd3, 3'd3, 3'd6, 1'b0, 0, '0);
        wait_idle();
        chk("t4_r3", last_data, 32'h1234_5678);

        // Dependent back-to-back operations
        do_op(3'd0, 3'd1, 3'd2, 3'd4, 1'b0, 0, '0);
        wait_idle();
        chk("t6_r4", last_data, 32'h1);
        do_op(3'd1, 3'd4, 3'd1, 3'd5, 1'b0, 0, '0);
        wait_idle();
        chk("t6_r5", last_data, 32'hFFFF_FFFF);

        // Reset while the ALU is enabled
        cmd_valid = 1'b1;
        cmd_mode  = 3'd7;
        cmd_ra    = 3'd1;
        cmd_rb    = 3'd2;
        cmd_rd    = 3'd4;
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        reset_checks("t5");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd1, 3'd4, 3'd4, 3'd6, 1'b0, 0, '0);
        wait_idle();
        chk("t5_r4", last_data, 32'h0);
        chk("t5_zero", last_zero, 1'b1);

        // Randomised traffic
        ld_rand = 1;
        rr_rand = 1;
        for (int n = 0; n < 300; n++) begin
            do_op(3'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), rand_word());
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        ld_rand = 0;
        rr_rand = 0;
        wait_idle();
        repeat (3) tick();
        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("op_queue_empty", op_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
